// File: rtl/mux_scan_reg_if.sv
// Channel bank, select and registered view for mux_scan_reg.
// The master drives the inputs and the slave (the mux) drives the view.
interface mux_scan_reg_if #(
  parameter int CHANNELS = 32,
  parameter int WIDTH    = 1
);
  localparam int SEL_W =
    (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in;
  logic [SEL_W-1:0]          sel;
  logic                      scan_en;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      sel_err;
  logic                      wrap;

  modport master (
    output in, sel, scan_en,
    input  out, out_sel, out_valid,
    input  sel_err, wrap
  );

  modport slave (
    input  in, sel, scan_en,
    output out, out_sel, out_valid,
    output sel_err, wrap
  );
endinterface

// File: rtl/mux_scan_reg.sv
// Registered N-channel W-bit mux with a direct mode
// and an autonomous scan that dwells DWELL cycles per channel.
module mux_scan_reg #(
  parameter int CHANNELS = 32,
  parameter int WIDTH    = 1,
  parameter int DWELL    = 4
) (
  input logic           clk,
  input logic           rst,
  mux_scan_reg_if.slave bus
);
  localparam int SEL_W =
    (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [SEL_W-1:0] SEL_LAST =
    SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DWELL - 1);

  typedef enum logic {
    S_DIRECT,
    S_SCAN
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic             wrap_q, wrap_d;

  logic             sel_legal;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] ptr_data;

  assign sel_legal = (32'(bus.sel) < 32'(CHANNELS));

  // Explicit compare chains keep illegal selects off the bus.
  always_comb begin
    sel_data = '0;
    ptr_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.sel == SEL_W'(k))
        sel_data = bus.in[k*WIDTH +: WIDTH];
      if (ptr_q == SEL_W'(k))
        ptr_data = bus.in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    wrap_d      = 1'b0;
    unique case (state_q)
      S_DIRECT: begin
        out_sel_d   = bus.sel;
        out_d       = sel_legal ? sel_data : '0;
        out_valid_d = sel_legal;
        sel_err_d   = ~sel_legal;
        if (bus.scan_en) begin
          state_d = S_SCAN;
          ptr_d   = sel_legal ? bus.sel : '0;
          cnt_d   = '0;
        end
      end
      S_SCAN: begin
        out_d       = ptr_data;
        out_sel_d   = ptr_q;
        out_valid_d = 1'b1;
        sel_err_d   = 1'b0;
        if (!bus.scan_en) begin
          state_d = S_DIRECT;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d  = '0;
          wrap_d = (ptr_q == SEL_LAST);
          ptr_d  = (ptr_q == SEL_LAST) ? '0
                 : ptr_q + SEL_W'(1);
        end
      end
      default: state_d = S_DIRECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_DIRECT;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg: three geometries
// (32x1, 4x8, 24x1) sharing one clock.
module tb_mux_scan_reg;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mux_scan_reg_if #(.CHANNELS(32), .WIDTH(1)) b32 ();
  mux_scan_reg_if #(.CHANNELS(4),  .WIDTH(8)) b4  ();
  mux_scan_reg_if #(.CHANNELS(24), .WIDTH(1)) b24 ();

  mux_scan_reg #(.CHANNELS(32), .WIDTH(1), .DWELL(4))
    u32 (.clk(clk), .rst(rst), .bus(b32));
  mux_scan_reg #(.CHANNELS(4), .WIDTH(8), .DWELL(4))
    u4 (.clk(clk), .rst(rst), .bus(b4));
  mux_scan_reg #(.CHANNELS(24), .WIDTH(1), .DWELL(4))
    u24 (.clk(clk), .rst(rst), .bus(b24));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] v;
    int          es;

    rst = 1'b1;
    b32.in = '0; b32.sel = '0; b32.scan_en = 1'b0;
    b4.in  = '0; b4.sel  = '0; b4.scan_en  = 1'b0;
    b24.in = '0; b24.sel = '0; b24.scan_en = 1'b0;
    tick();
    tick();
    chk("rst_out",   32'(b32.out),       0);
    chk("rst_sel",   32'(b32.out_sel),   0);
    chk("rst_valid", 32'(b32.out_valid), 0);
    chk("rst_err",   32'(b32.sel_err),   0);
    chk("rst_wrap",  32'(b32.wrap),      0);
    rst = 1'b0;

    // 32x1 direct
    b32.in = 32'h0AB000A0;
    b32.sel = 5'd5;
    tick();
    chk("d32_out5",   32'(b32.out),       1);
    chk("d32_sel5",   32'(b32.out_sel),   5);
    chk("d32_valid5", 32'(b32.out_valid), 1);
    b32.sel = 5'd2;
    tick();
    chk("d32_out2", 32'(b32.out), 0);
    chk("d32_sel2", 32'(b32.out_sel), 2);

    // 4x8 direct, live tracking
    b4.in = 32'hD0D020E0;
    b4.sel = 2'd2;
    tick();
    chk("d4_ch2", 32'(b4.out), 32'hD0);
    b4.sel = 2'd0;
    tick();
    chk("d4_ch0", 32'(b4.out), 32'hE0);
    b4.sel = 2'd1;
    tick();
    chk("d4_ch1", 32'(b4.out), 32'h20);
    b4.in = 32'hD0D021E0;
    tick();
    chk("d4_ch1_live", 32'(b4.out), 32'h21);

    // 24x1 out-of-range select
    b24.in = 24'hFFFFFF;
    b24.sel = 5'd26;
    tick();
    chk("d24_out26",   32'(b24.out),       0);
    chk("d24_valid26", 32'(b24.out_valid), 0);
    chk("d24_err26",   32'(b24.sel_err),   1);
    chk("d24_sel26",   32'(b24.out_sel),   26);
    b24.sel = 5'd23;
    tick();
    chk("d24_valid23", 32'(b24.out_valid), 1);
    chk("d24_err23",   32'(b24.sel_err),   0);
    chk("d24_out23",   32'(b24.out),       1);

    // 32x1 scan from 30 through wrap
    v = 32'h80000002;
    b32.in = v;
    b32.sel = 5'd30;
    b32.scan_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        v = ~v;
        b32.in = v;
      end
      tick();
      es = (i < 5) ? 30 : (i < 9) ? 31 : (i < 13) ? 0 : 1;
      chk($sformatf("scan_sel_%0d", i),
          32'(b32.out_sel), 32'(es));
      chk($sformatf("scan_out_%0d", i),
          32'(b32.out), 32'(v[es]));
      chk($sformatf("scan_wrap_%0d", i),
          32'(b32.wrap), (i == 8) ? 1 : 0);
      chk($sformatf("scan_valid_%0d", i),
          32'(b32.out_valid), 1);
    end

    // exit while cnt is at its last value
    b32.scan_en = 1'b0;
    b32.sel = 5'd7;
    tick();
    chk("exit_hold_sel",  32'(b32.out_sel), 1);
    chk("exit_hold_wrap", 32'(b32.wrap),    0);
    chk("exit_hold_out",  32'(b32.out),     32'(v[1]));
    tick();
    chk("exit_dir_sel",  32'(b32.out_sel), 7);
    chk("exit_dir_out",  32'(b32.out),     32'(v[7]));
    chk("exit_dir_wrap", 32'(b32.wrap),    0);

    // reset mid-scan with scan_en held
    b32.sel = 5'd10;
    b32.scan_en = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_out",   32'(b32.out),       0);
    chk("mrst_sel",   32'(b32.out_sel),   0);
    chk("mrst_valid", 32'(b32.out_valid), 0);
    chk("mrst_wrap",  32'(b32.wrap),      0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      es = (i < 5) ? 10 : 11;
      chk($sformatf("rescan_sel_%0d", i),
          32'(b32.out_sel), 32'(es));
      chk($sformatf("rescan_out_%0d", i),
          32'(b32.out), 32'(v[es]));
    end

    // 24x1 illegal sel entering scan starts at 0
    b24.sel = 5'd26;
    b24.scan_en = 1'b1;
    tick();
    chk("s24_entry_valid", 32'(b24.out_valid), 0);
    chk("s24_entry_err",   32'(b24.sel_err),   1);
    chk("s24_entry_sel",   32'(b24.out_sel),   26);
    for (int i = 1; i < 6; i++) begin
      tick();
      chk($sformatf("s24_sel_%0d", i),
          32'(b24.out_sel), (i < 5) ? 0 : 1);
      chk($sformatf("s24_err_%0d", i),
          32'(b24.sel_err), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
